alu_op_scheduler: RTL and testbench
===================================

Name: alu_op_scheduler

Overview:
- Shares one ALU datapath (arithmetic, logic, compare and shift units, each with an enable and a registered output) between two requesters.
- Arbitrates requests round-robin and decodes the 4-bit function code into a one-hot unit enable plus a 2-bit unit function.
- Sequences issue and capture across the units' one-cycle registered latency, and returns the result with a valid/ready handshake tagged by requester ID.
- Sits between the instruction/command front end and the ALU unit instances.

Parameters:
- IN_DATA_WD, 16, operand width.
- OUT_WD, IN_DATA_WD, result width.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  synchronous, active-high reset.
- REQ0_VALID  in  1  requester 0 has an operation.
- REQ0_READY  out  1  requester 0 operation accepted this cycle.
- REQ0_A, REQ0_B  in  IN_DATA_WD  requester 0 operands.
- REQ0_FUN  in  4  requester 0 function code.
- REQ1_VALID, REQ1_READY, REQ1_A, REQ1_B, REQ1_FUN: same as above, for requester 1.
- UNIT_A, UNIT_B  out  IN_DATA_WD  operands driven to all units.
- ARITH_EN, LOGIC_EN, CMP_EN, SHIFT_EN  out  1  unit enables; at most one is high.
- UNIT_FUN  out  2  function select to the units.
- UNIT_OUT  in  OUT_WD  OR of all unit outputs. Disabled units drive 0.
- UNIT_FLAG  in  1  OR of all unit valid flags.
- RES_VALID  out  1  result available.
- RES_READY  in  1  consumer accepts the result.
- RES_DATA  out  OUT_WD  captured result.
- RES_ID  out  1  requester that issued the operation.
- RES_ERR  out  1  unit flag was missing at capture.
- OP_CNT  out  16  completed operations; wraps at 16'hFFFF -> 0.

Behaviour:
- Reset: RST sampled at CLK rising edge. The following are 0 after reset: all outputs, state, operand and ID registers. The round-robin pointer is set so REQ0 has priority on the first arbitration.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - The winner is the valid requester. If both are valid, the one not granted last wins.
  - Only the winner's REQx_READY is high, combinationally, and only in IDLE.
  - On VALID&READY: latch A, B, FUN and ID; update the pointer; go to ISSUE.
  - REQx_READY is 0 in all other states.
- FUN decode:
  - FUN[3:2]: 00 arith, 01 logic, 10 cmp, 11 shift.
  - UNIT_FUN = FUN[1:0].
- ISSUE (one cycle):
  - The decoded enable is high and UNIT_A/UNIT_B carry the latched operands. The unit registers at the closing edge.
  - Go to WAIT.
- WAIT (one cycle):
  - All enables are low; operands are held.
  - At the closing edge, RES_DATA <= UNIT_OUT, RES_ID <= latched ID, RES_ERR <= ~UNIT_FLAG.
  - If UNIT_FLAG = 0, RES_DATA <= 0.
  - Go to RESP.
- RESP:
  - RES_VALID = 1 and RES_DATA/RES_ID/RES_ERR are stable until RES_READY.
  - On RES_VALID&RES_READY: OP_CNT increments (including error results); go to IDLE; RES_VALID drops the next cycle.
- Latency: accept edge to RES_VALID high is 3 cycles. Minimum issue interval is 4 cycles with RES_READY tied high.
- No new request is accepted while an operation is outstanding; a held REQx_VALID waits.
- RST asserted in any state aborts the operation: no response, enables low at the next edge, OP_CNT cleared.
- A request and RES_READY in the same cycle cannot conflict, because READY is issued only in IDLE.

Test Plan:
- Reset, then REQ0 FUN=4'b0100, A=16'h00F0, B=16'h0FF0 -> LOGIC_EN high for exactly 1 cycle with UNIT_FUN=00; RES_DATA=16'h00F0, RES_ID=0, RES_ERR=0 three cycles after accept; OP_CNT=1.
- REQ0 and REQ1 both valid continuously with FUN=0101 and RES_READY=1 -> grants alternate 0,1,0,1; accept edges 4 cycles apart; REQx_READY never high together.
- Hold RES_READY=0 for 5 cycles in RESP with both requesters valid -> RES_DATA stable; no REQx_READY; OP_CNT unchanged until the handshake.
- Model the unit returning UNIT_FLAG=0 in WAIT -> RES_ERR=1, RES_DATA=0, OP_CNT still increments.
- Assert RST for 1 cycle during ISSUE -> enables 0 next cycle; no RES_VALID; OP_CNT=0; next request is arbitrated REQ0-first.
- Preload OP_CNT near 16'hFFFF (force), complete 2 operations -> OP_CNT goes 16'hFFFF then 16'h0000.

Source files
------------

// File: rtl/alu_op_scheduler.sv
// alu_op_scheduler: shares one ALU datapath (arith, logic, compare, shift
// units) between two requesters. Requests are granted round-robin, the
// function code is decoded into a one-hot unit enable, the registered unit
// output is captured one cycle after issue, and the result is returned over
// a valid/ready handshake tagged with the requester ID.
//
// Handshake rules: a transfer happens on a rising CLK edge where both VALID
// and READY are high. REQx_READY is offered only in IDLE and only to the
// arbitration winner; it depends combinationally on REQx_VALID. RES_VALID is
// high for the whole response phase, and RES_DATA/RES_ID/RES_ERR stay stable
// until RES_READY completes the transfer.

module alu_op_scheduler #(
    parameter int IN_DATA_WD = 16,
    parameter int OUT_WD     = IN_DATA_WD
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  REQ0_VALID,
    output logic                  REQ0_READY,
    input  logic [IN_DATA_WD-1:0] REQ0_A,
    input  logic [IN_DATA_WD-1:0] REQ0_B,
    input  logic [3:0]            REQ0_FUN,
    input  logic                  REQ1_VALID,
    output logic                  REQ1_READY,
    input  logic [IN_DATA_WD-1:0] REQ1_A,
    input  logic [IN_DATA_WD-1:0] REQ1_B,
    input  logic [3:0]            REQ1_FUN,
    output logic [IN_DATA_WD-1:0] UNIT_A,
    output logic [IN_DATA_WD-1:0] UNIT_B,
    output logic                  ARITH_EN,
    output logic                  LOGIC_EN,
    output logic                  CMP_EN,
    output logic                  SHIFT_EN,
    output logic [1:0]            UNIT_FUN,
    input  logic [OUT_WD-1:0]     UNIT_OUT,
    input  logic                  UNIT_FLAG,
    output logic                  RES_VALID,
    input  logic                  RES_READY,
    output logic [OUT_WD-1:0]     RES_DATA,
    output logic                  RES_ID,
    output logic                  RES_ERR,
    output logic [15:0]           OP_CNT,
    output logic [1:0]            DBG_STATE
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    logic [1:0]            state;
    logic                  last_id;     // requester granted most recently
    logic [IN_DATA_WD-1:0] a_q;
    logic [IN_DATA_WD-1:0] b_q;
    logic [3:0]            fun_q;
    logic                  id_q;
    logic [OUT_WD-1:0]     res_data_q;
    logic                  res_id_q;
    logic                  res_err_q;
    logic [15:0]           op_cnt_q;

    logic                  grant_any;
    logic                  grant_id;

    // Round-robin arbitration: a lone valid requester wins; on a tie the
    // requester that was not granted last wins. Only active in IDLE.
    always_comb begin
        grant_any = 1'b0;
        grant_id  = 1'b0;
        if (state == ST_IDLE) begin
            if (REQ0_VALID && REQ1_VALID) begin
                grant_any = 1'b1;
                grant_id  = ~last_id;
            end else if (REQ0_VALID) begin
                grant_any = 1'b1;
                grant_id  = 1'b0;
            end else if (REQ1_VALID) begin
                grant_any = 1'b1;
                grant_id  = 1'b1;
            end
        end
    end

    assign REQ0_READY = grant_any & ~grant_id;
    assign REQ1_READY = grant_any &  grant_id;

    // Sequencer: accept, issue for one cycle, wait out the unit register,
    // capture, then hold the response until the consumer takes it.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= ST_IDLE;
            last_id    <= 1'b1;          // makes REQ0 win the first tie
            a_q        <= '0;
            b_q        <= '0;
            fun_q      <= '0;
            id_q       <= 1'b0;
            res_data_q <= '0;
            res_id_q   <= 1'b0;
            res_err_q  <= 1'b0;
            op_cnt_q   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant_any) begin
                        a_q     <= grant_id ? REQ1_A   : REQ0_A;
                        b_q     <= grant_id ? REQ1_B   : REQ0_B;
                        fun_q   <= grant_id ? REQ1_FUN : REQ0_FUN;
                        id_q    <= grant_id;
                        last_id <= grant_id;
                        state   <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    // A missing unit flag means the unit output is not
                    // trustworthy, so the data is zeroed and flagged.
                    res_data_q <= UNIT_FLAG ? UNIT_OUT : '0;
                    res_id_q   <= id_q;
                    res_err_q  <= ~UNIT_FLAG;
                    state      <= ST_RESP;
                end
                ST_RESP: begin
                    if (RES_READY) begin
                        op_cnt_q <= op_cnt_q + 16'd1;
                        state    <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Unit enable decode: exactly one unit enabled, and only during ISSUE.
    always_comb begin
        ARITH_EN = 1'b0;
        LOGIC_EN = 1'b0;
        CMP_EN   = 1'b0;
        SHIFT_EN = 1'b0;
        if (state == ST_ISSUE) begin
            case (fun_q[3:2])
                2'b00:   ARITH_EN = 1'b1;
                2'b01:   LOGIC_EN = 1'b1;
                2'b10:   CMP_EN   = 1'b1;
                default: SHIFT_EN = 1'b1;
            endcase
        end
    end

    assign UNIT_A    = a_q;
    assign UNIT_B    = b_q;
    assign UNIT_FUN  = fun_q[1:0];
    assign RES_VALID = (state == ST_RESP);
    assign RES_DATA  = res_data_q;
    assign RES_ID    = res_id_q;
    assign RES_ERR   = res_err_q;
    assign OP_CNT    = op_cnt_q;
    assign DBG_STATE = state;

endmodule

// File: tb/tb_alu_op_scheduler.sv
// Bench for alu_op_scheduler: behavioural ALU units drive UNIT_OUT/UNIT_FLAG,
// and a transaction-level reference model predicts grants, enable timing,
// response contents and the operation counter.

module tb_alu_op_scheduler;

    localparam int W = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          v0, v1;
    logic [W-1:0]  a0, b0, a1, b1;
    logic [3:0]    f0, f1;
    logic          res_ready;
    logic          REQ0_READY, REQ1_READY;
    logic [W-1:0]  UNIT_A, UNIT_B;
    logic          ARITH_EN, LOGIC_EN, CMP_EN, SHIFT_EN;
    logic [1:0]    UNIT_FUN;
    logic [W-1:0]  UNIT_OUT;
    logic          UNIT_FLAG;
    logic          RES_VALID;
    logic [W-1:0]  RES_DATA;
    logic          RES_ID, RES_ERR;
    logic [15:0]   OP_CNT;
    logic [1:0]    DBG_STATE;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    alu_op_scheduler #(.IN_DATA_WD(W), .OUT_WD(W)) dut (
        .CLK(clk), .RST(rst),
        .REQ0_VALID(v0), .REQ0_READY(REQ0_READY), .REQ0_A(a0), .REQ0_B(b0), .REQ0_FUN(f0),
        .REQ1_VALID(v1), .REQ1_READY(REQ1_READY), .REQ1_A(a1), .REQ1_B(b1), .REQ1_FUN(f1),
        .UNIT_A(UNIT_A), .UNIT_B(UNIT_B),
        .ARITH_EN(ARITH_EN), .LOGIC_EN(LOGIC_EN), .CMP_EN(CMP_EN), .SHIFT_EN(SHIFT_EN),
        .UNIT_FUN(UNIT_FUN), .UNIT_OUT(UNIT_OUT), .UNIT_FLAG(UNIT_FLAG),
        .RES_VALID(RES_VALID), .RES_READY(res_ready), .RES_DATA(RES_DATA),
        .RES_ID(RES_ID), .RES_ERR(RES_ERR), .OP_CNT(OP_CNT), .DBG_STATE(DBG_STATE)
    );

    // ---------------- ALU unit functions ----------------
    function automatic logic [W-1:0] arith_u(input logic [1:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
        case (f)
            2'd0:    return a + b;
            2'd1:    return a - b;
            2'd2:    return a + 16'd1;
            default: return b - a;
        endcase
    endfunction

    function automatic logic [W-1:0] logic_u(input logic [1:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
        case (f)
            2'd0:    return a & b;
            2'd1:    return a | b;
            2'd2:    return a ^ b;
            default: return ~a;
        endcase
    endfunction

    function automatic logic [W-1:0] cmp_u(input logic [1:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
        case (f)
            2'd0:    return (a == b) ? 16'd1 : 16'd0;
            2'd1:    return (a < b) ? 16'd1 : 16'd0;
            2'd2:    return (a > b) ? 16'd1 : 16'd0;
            default: return ($signed(a) < $signed(b)) ? 16'd1 : 16'd0;
        endcase
    endfunction

    function automatic logic [W-1:0] shift_u(input logic [1:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
        int sh;
        sh = int'(b[3:0]);
        case (f)
            2'd0:    return a << sh;
            2'd1:    return a >> sh;
            2'd2:    return $signed(a) >>> sh;
            default: return (a << sh) | (a >> (16 - sh));
        endcase
    endfunction

    // Whole-operation reference: what the selected unit produces for a code.
    function automatic logic [W-1:0] alu_ref(input logic [3:0] fun, input logic [W-1:0] a, input logic [W-1:0] b);
        case (fun[3:2])
            2'd0:    return arith_u(fun[1:0], a, b);
            2'd1:    return logic_u(fun[1:0], a, b);
            2'd2:    return cmp_u(fun[1:0], a, b);
            default: return shift_u(fun[1:0], a, b);
        endcase
    endfunction

    // ---------------- behavioural units (registered, OR-combined) ----------------
    logic [W-1:0] unit_out_q  = '0;
    logic         unit_flag_q = 1'b0;
    logic         bad_flag    = 1'b0;

    always @(posedge clk) begin
        unit_out_q  <= (ARITH_EN ? arith_u(UNIT_FUN, UNIT_A, UNIT_B) : 16'd0)
                     | (LOGIC_EN ? logic_u(UNIT_FUN, UNIT_A, UNIT_B) : 16'd0)
                     | (CMP_EN   ? cmp_u(UNIT_FUN, UNIT_A, UNIT_B)   : 16'd0)
                     | (SHIFT_EN ? shift_u(UNIT_FUN, UNIT_A, UNIT_B) : 16'd0);
        unit_flag_q <= (ARITH_EN | LOGIC_EN | CMP_EN | SHIFT_EN) & ~bad_flag;
    end

    assign UNIT_OUT  = unit_out_q;
    assign UNIT_FLAG = unit_flag_q;

    // ---------------- reference model / scoreboard ----------------
    int           checks = 0;
    int           errors = 0;
    int           cyc = 0;
    bit           m_busy = 1'b0;
    int           m_age = 0;          // cycles since the accept edge
    bit           m_last = 1'b1;
    logic [15:0]  m_cnt = '0;
    logic [3:0]   m_fun;
    logic [W-1:0] m_a, m_b;
    logic [W+1:0] exp_q[$];           // {id, err, data}
    int           acc_id_q[$];
    int           acc_cyc_q[$];
    bit           acc0, acc1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_busy = 1'b0;
        m_age  = 0;
        m_last = 1'b1;
        m_cnt  = '0;
        exp_q.delete();
    endtask

    // ---------------- driver tasks ----------------
    // Called at a falling edge with inputs already set; checks the cycle,
    // advances one rising edge, updates the model, returns at the next fall.
    task automatic step_cycle();
        logic         er0, er1, ev, hs;
        logic [3:0]   een;
        logic [W+1:0] e;
        logic [W-1:0] d;
        #1;
        er0 = 1'b0;
        er1 = 1'b0;
        if (!m_busy) begin
            if (v0 && v1) begin
                er0 = ~(~m_last);
                er1 = ~m_last;
                er0 = ~er1;
            end else begin
                er0 = v0;
                er1 = v1;
            end
        end
        check("req0_ready", REQ0_READY, er0);
        check("req1_ready", REQ1_READY, er1);
        check("ready_excl", REQ0_READY & REQ1_READY, 0);
        ev = m_busy && (m_age >= 3);
        check("res_valid", RES_VALID, ev);
        een = (m_busy && m_age == 1) ? (4'b1000 >> m_fun[3:2]) : 4'b0000;
        check("enables", {ARITH_EN, LOGIC_EN, CMP_EN, SHIFT_EN}, een);
        if (m_busy && (m_age == 1 || m_age == 2)) begin
            check("unit_a", UNIT_A, m_a);
            check("unit_b", UNIT_B, m_b);
        end
        if (m_busy && m_age == 1) check("unit_fun", UNIT_FUN, m_fun[1:0]);
        if (ev) begin
            e = exp_q[0];
            check("res_data", RES_DATA, e[W-1:0]);
            check("res_err", RES_ERR, e[W]);
            check("res_id", RES_ID, e[W+1]);
        end
        check("op_cnt", OP_CNT, m_cnt);
        hs   = ev && res_ready;
        acc0 = er0 && !rst;
        acc1 = er1 && !rst;
        @(posedge clk);
        cyc++;
        if (rst) begin
            model_reset();
        end else if (acc0 || acc1) begin
            m_busy = 1'b1;
            m_age  = 1;
            m_last = acc1;
            m_a    = acc1 ? a1 : a0;
            m_b    = acc1 ? b1 : b0;
            m_fun  = acc1 ? f1 : f0;
            d      = bad_flag ? 16'd0 : alu_ref(m_fun, m_a, m_b);
            exp_q.push_back({acc1, bad_flag, d});
            acc_id_q.push_back(int'(acc1));
            acc_cyc_q.push_back(cyc);
        end else if (m_busy) begin
            if (hs) begin
                m_busy = 1'b0;
                m_cnt  = m_cnt + 16'd1;
                void'(exp_q.pop_front());
            end else begin
                m_age++;
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic drain();
        v0 = 1'b0;
        v1 = 1'b0;
        res_ready = 1'b1;
        for (int k = 0; k < 10 && m_busy; k++) step_cycle();
        check("drain_idle", RES_VALID, 0);
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        logic [W-1:0] snap_d;
        logic [15:0]  snap_c;
        rst = 1'b1; v0 = 0; v1 = 0; res_ready = 1'b1;
        a0 = '0; b0 = '0; f0 = '0; a1 = '0; b1 = '0; f1 = '0;
        do_reset();

        // reset state
        check("rst_ready0", REQ0_READY, 0);
        check("rst_ready1", REQ1_READY, 0);
        check("rst_valid", RES_VALID, 0);
        check("rst_en", {ARITH_EN, LOGIC_EN, CMP_EN, SHIFT_EN}, 0);
        check("rst_unit_a", UNIT_A, 0);
        check("rst_unit_b", UNIT_B, 0);
        check("rst_unit_fun", UNIT_FUN, 0);
        check("rst_data", RES_DATA, 0);
        check("rst_id", RES_ID, 0);
        check("rst_err", RES_ERR, 0);
        check("rst_cnt", OP_CNT, 0);
        check("rst_state", DBG_STATE, 0);

        // single logic AND from requester 0
        v0 = 1'b1; f0 = 4'b0100; a0 = 16'h00F0; b0 = 16'h0FF0;
        step_cycle();
        check("t1_accept", acc0, 1);
        v0 = 1'b0;
        check("t1_logic_en", LOGIC_EN, 1);
        check("t1_unit_fun", UNIT_FUN, 2'b00);
        step_cycle();
        check("t1_logic_en_off", LOGIC_EN, 0);
        step_cycle();
        check("t1_valid", RES_VALID, 1);
        check("t1_data", RES_DATA, 16'h00F0);
        check("t1_id", RES_ID, 0);
        check("t1_err", RES_ERR, 0);
        step_cycle();
        check("t1_cnt", OP_CNT, 1);

        // both requesters continuously valid: alternating grants, 4-cycle spacing
        do_reset();
        acc_id_q.delete();
        acc_cyc_q.delete();
        v0 = 1'b1; v1 = 1'b1; f0 = 4'b0101; f1 = 4'b0101;
        a0 = 16'($urandom); b0 = 16'($urandom); a1 = 16'($urandom); b1 = 16'($urandom);
        repeat (16) begin
            step_cycle();
            if (acc0) begin a0 = 16'($urandom); b0 = 16'($urandom); end
            if (acc1) begin a1 = 16'($urandom); b1 = 16'($urandom); end
        end
        check("t2_grants", acc_id_q.size(), 4);
        for (int i = 0; i < acc_id_q.size(); i++) begin
            check("t2_grant_id", acc_id_q[i], i % 2);
            if (i > 0) check("t2_interval", acc_cyc_q[i] - acc_cyc_q[i-1], 4);
        end
        drain();

        // response back-pressure with both requesters waiting
        v0 = 1'b1; v1 = 1'b1; f0 = 4'($urandom); f1 = 4'($urandom);
        res_ready = 1'b0;
        for (int k = 0; k < 12 && !(m_busy && m_age == 3); k++) step_cycle();
        check("t3_in_resp", RES_VALID, 1);
        snap_d = RES_DATA;
        snap_c = m_cnt;
        repeat (5) begin
            step_cycle();
            check("t3_data_stable", RES_DATA, snap_d);
            check("t3_cnt_held", OP_CNT, snap_c);
            check("t3_no_ready", {REQ0_READY, REQ1_READY}, 2'b00);
        end
        res_ready = 1'b1;
        step_cycle();
        check("t3_cnt_after", OP_CNT, snap_c + 16'd1);
        drain();

        // unit flag missing at capture
        snap_c = m_cnt;
        bad_flag = 1'b1;
        v1 = 1'b1; f1 = 4'b0000; a1 = 16'h1234; b1 = 16'h0101;
        step_cycle();
        v1 = 1'b0;
        step_cycle();
        step_cycle();
        check("t4_err", RES_ERR, 1);
        check("t4_data", RES_DATA, 0);
        check("t4_id", RES_ID, 1);
        step_cycle();
        bad_flag = 1'b0;
        check("t4_cnt", OP_CNT, snap_c + 16'd1);

        // reset during ISSUE aborts the operation
        v0 = 1'b1; f0 = 4'b1100; a0 = 16'h0003; b0 = 16'h0002;
        step_cycle();
        v0 = 1'b0;
        check("t5_issue_en", SHIFT_EN, 1);
        rst = 1'b1;
        step_cycle();
        rst = 1'b0;
        check("t5_en_off", {ARITH_EN, LOGIC_EN, CMP_EN, SHIFT_EN}, 0);
        check("t5_cnt", OP_CNT, 0);
        repeat (4) begin
            step_cycle();
            check("t5_no_valid", RES_VALID, 0);
        end
        v0 = 1'b1; v1 = 1'b1;
        step_cycle();
        check("t5_req0_first", acc0, 1);
        drain();

        // counter wrap
        force dut.op_cnt_q = 16'hFFFE;
        #1;
        release dut.op_cnt_q;
        m_cnt = 16'hFFFE;
        v0 = 1'b1; f0 = 4'b1001;
        step_cycle();
        v0 = 1'b0;
        repeat (3) step_cycle();
        check("t6_cnt_ffff", OP_CNT, 16'hFFFF);
        v1 = 1'b1; f1 = 4'b0010;
        step_cycle();
        v1 = 1'b0;
        repeat (3) step_cycle();
        check("t6_cnt_wrap", OP_CNT, 16'h0000);

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            if (!v0 && $urandom_range(0, 1) == 1) begin
                v0 = 1'b1; f0 = 4'($urandom); a0 = 16'($urandom); b0 = 16'($urandom);
            end
            if (!v1 && $urandom_range(0, 1) == 1) begin
                v1 = 1'b1; f1 = 4'($urandom); a1 = 16'($urandom); b1 = 16'($urandom);
            end
            res_ready = ($urandom_range(0, 3) != 0);
            if (!m_busy) bad_flag = ($urandom_range(0, 7) == 0);
            step_cycle();
            if (acc0) v0 = 1'b0;
            if (acc1) v1 = 1'b0;
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
